// File: rtl/tick_ctrl.sv
// tick_ctrl: CLOCK_50 prescaler emitting a one-cycle tick, with debounced run/pause key and,
// when STEP_EN is defined, a single-step key; KEY[0] is the async active-low reset.
module tick_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  output logic       tick,
  output logic       running
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DB  = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = DB > 1 ? $clog2(DB) : 1;
`ifdef STEP_EN
  localparam int NK = 2;
`else
  localparam int NK = 1;
  logic unused_step_key;
  assign unused_step_key = KEY[2];
`endif

  typedef enum logic [1:0] {RUNNING, PAUSED, STEP} state_t;

  logic [1:0] rs_q;
  logic       rst_n;
  logic [NK-1:0] ev;
  logic       run_ev, step_ev, wrap, tick_d;
  logic [PW-1:0] pre_q, pre_d;
  state_t     state_q, state_d;

  // Reset asserts immediately but releases two edges later, away from KEY[0] timing.
  always_ff @(posedge CLOCK_50 or negedge KEY[0])
    if (!KEY[0]) rs_q <= '0;
    else rs_q <= {rs_q[0], 1'b1};
  assign rst_n = rs_q[1];

  for (genvar k = 0; k < NK; k++) begin : g_key
    logic s1_q, s_q, d_q, d_d, ev_q, hit;
    logic [DW-1:0] cnt_q, cnt_d;
    assign hit   = s_q != d_q && cnt_q == DW'(DB - 1);
    assign d_d   = hit ? s_q : d_q;
    assign cnt_d = (s_q != d_q && !hit) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) begin
        s1_q  <= 1'b1;
        s_q   <= 1'b1;
        d_q   <= 1'b1;
        cnt_q <= '0;
        ev_q  <= 1'b0;
      end else begin
        s1_q  <= KEY[k+1];
        s_q   <= s1_q;
        d_q   <= d_d;
        cnt_q <= cnt_d;
        ev_q  <= d_q & ~d_d;
      end
    assign ev[k] = ev_q;
  end

  assign run_ev = ev[0];
`ifdef STEP_EN
  assign step_ev = ev[1];
`else
  assign step_ev = 1'b0;
`endif
  assign wrap = pre_q == PW'(DIV - 1);

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    tick_d  = 1'b0;
    case (state_q)
      RUNNING: begin
        tick_d  = wrap;
        pre_d   = (run_ev || wrap) ? '0 : pre_q + 1'b1;
        state_d = run_ev ? PAUSED : RUNNING;
      end
      PAUSED:  state_d = run_ev ? RUNNING : step_ev ? STEP : PAUSED;
      STEP: begin
        tick_d  = 1'b1;
        state_d = PAUSED;
      end
      default: state_d = RUNNING;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUNNING;
      pre_q   <= '0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick    <= tick_d;
    end

  assign running = state_q == RUNNING;
endmodule
